// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - SCAN-ordered call panel feeding the elevator controller
//
// Latches per-floor call buttons, picks one target floor at a time
// (same-direction-first), drives it one-hot to the controller, and runs
// a door dwell once the car stops at the target.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   btn          per-floor call buttons, level, synchronous to clk
//   car_floor    binary car position from the controller
//   car_stopped  controller is in its stopped/idle condition
//   floor_req    one-hot target floor; all-zero means no request
//   pending      latched calls (lamps)
//   door_open    door dwell in progress
//   dir_up       current scan direction, 1 = up
//   busy         high while serving a target or dwelling
module elevator_call_panel #(
  parameter int N_FLOORS     = 5,
  parameter int FW           = 3,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [FW-1:0]       car_floor,
  input  logic                car_stopped,
  output logic [N_FLOORS-1:0] floor_req,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open,
  output logic                dir_up,
  output logic                busy
);

  localparam int              CW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]   DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [FW:0]     N_LIMIT    = (FW+1)'(N_FLOORS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DOOR  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [N_FLOORS-1:0] btn_q;
  logic [N_FLOORS-1:0] rise;
  logic [N_FLOORS-1:0] at_mask;
  logic [N_FLOORS-1:0] absorb;
  logic [N_FLOORS-1:0] pend_clr;
  logic [N_FLOORS-1:0] req_n;
  logic [FW-1:0]       tgt, tgt_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                dir_n;
  logic                car_valid;

  logic                up_hit, dn_hit;
  logic [FW-1:0]       up_f, dn_f;
  logic                ahead_hit, behind_hit, sel_hit, retarget;
  logic [FW-1:0]       ahead_f, behind_f, sel_f;

  function automatic logic [N_FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [N_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < N_FLOORS; i++) v[i] = (f == FW'(i));
    return v;
  endfunction

  // An out-of-range position matches no floor, so nothing is ever served
  // or cleared until the controller reports a real floor again.
  assign car_valid = ({1'b0, car_floor} < N_LIMIT);
  assign at_mask   = car_valid ? onehot(car_floor) : '0;

  assign rise      = btn & ~btn_q;
  // A press at the open-door floor extends the dwell instead of becoming a call.
  assign absorb    = (state == DOOR) ? (rise & at_mask) : '0;

  // Nearest pending call above and below the car; the call at the car's
  // own floor is excluded by the strict comparisons.
  always_comb begin
    up_hit = 1'b0;
    up_f   = '0;
    dn_hit = 1'b0;
    dn_f   = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FW'(i) > car_floor)) begin
        up_hit = 1'b1;
        up_f   = FW'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i] && (FW'(i) < car_floor)) begin
        dn_hit = 1'b1;
        dn_f   = FW'(i);
      end
    end
    if (!car_valid) begin
      up_hit = 1'b0;
      dn_hit = 1'b0;
    end
  end

  assign ahead_hit  = dir_up ? up_hit : dn_hit;
  assign ahead_f    = dir_up ? up_f   : dn_f;
  assign behind_hit = dir_up ? dn_hit : up_hit;
  assign behind_f   = dir_up ? dn_f   : up_f;
  assign sel_hit    = ahead_hit | behind_hit;
  assign sel_f      = ahead_hit ? ahead_f : behind_f;

  // While serving, the nearest call ahead is only taken over when it lies
  // strictly short of the current target.
  assign retarget   = ahead_hit && (dir_up ? (ahead_f < tgt) : (ahead_f > tgt));

  always_comb begin
    state_n  = state;
    tgt_n    = tgt;
    req_n    = floor_req;
    dir_n    = dir_up;
    cnt_n    = cnt;
    pend_clr = '0;
    case (state)
      IDLE: begin
        req_n = '0;
        if (car_stopped && |(pending & at_mask)) begin
          state_n  = DOOR;
          cnt_n    = DWELL_LOAD;
          pend_clr = at_mask;
        end else if (sel_hit) begin
          state_n = SERVE;
          tgt_n   = sel_f;
          req_n   = onehot(sel_f);
          dir_n   = (sel_f > car_floor);
        end
      end
      SERVE: begin
        if (car_stopped && car_valid && (car_floor == tgt)) begin
          state_n  = DOOR;
          req_n    = '0;
          cnt_n    = DWELL_LOAD;
          pend_clr = onehot(tgt);
        end else if (retarget) begin
          tgt_n = ahead_f;
          req_n = onehot(ahead_f);
        end
      end
      DOOR: begin
        req_n = '0;
        if (|(rise & at_mask)) begin
          cnt_n = DWELL_LOAD;
        end else if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      btn_q     <= '0;
      pending   <= '0;
      floor_req <= '0;
      dir_up    <= 1'b1;
      tgt       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      btn_q     <= btn;
      // Clear wins over a same-cycle set of the same bit.
      pending   <= (pending | (rise & ~absorb)) & ~pend_clr;
      floor_req <= req_n;
      dir_up    <= dir_n;
      tgt       <= tgt_n;
      cnt       <= cnt_n;
    end
  end

  assign door_open = (state == DOOR);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - scoreboard bench for elevator_call_panel
module tb_elevator_call_panel;

  localparam int N  = 5;
  localparam int DW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [2:0]   car_floor = 3'd0;
  logic         car_stopped = 1'b1;
  logic [N-1:0] floor_req;
  logic [N-1:0] pending;
  logic         door_open;
  logic         dir_up;
  logic         busy;

  elevator_call_panel #(
    .N_FLOORS     (N),
    .FW           (3),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .car_floor   (car_floor),
    .car_stopped (car_stopped),
    .floor_req   (floor_req),
    .pending     (pending),
    .door_open   (door_open),
    .dir_up      (dir_up),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int floor;
    bit dir;
    int dwell;
  } stop_t;

  typedef struct {
    string name;
    int    sel;
    int    val;
    int    exp;
  } dchk_t;

  stop_t        exp_stop[$];
  logic [N-1:0] exp_req[$];
  dchk_t        dq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit car_auto = 1'b0;
  int move_cnt = 0;
  bit mdir     = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sample(input int sel, input int val);
    case (sel)
      0:       return int'(floor_req);
      1:       return int'(pending);
      2:       return int'(door_open);
      3:       return int'(dir_up);
      4:       return int'(busy);
      default: return val;
    endcase
  endfunction

  // Monitor: evaluates posted directed checks, per-cycle invariants and the
  // request/stop scoreboard.
  initial begin : monitor
    logic [N-1:0] prev_req;
    logic         prev_door;
    int           door_cnt;
    int           cur_dwell;
    prev_req  = '0;
    prev_door = 1'b0;
    door_cnt  = 0;
    cur_dwell = DW;
    forever begin
      @(negedge clk);
      while (dq.size() != 0) begin
        dchk_t d;
        d = dq.pop_front();
        chk(d.name, sample(d.sel, d.val), d.exp);
      end
      if (rst) begin
        prev_req  = '0;
        prev_door = 1'b0;
        door_cnt  = 0;
      end else begin
        chk("busy_consistent", int'(busy), int'((floor_req != '0) || door_open));
        chk("req_subset_pending", int'(floor_req & ~pending), 0);
        if (floor_req != prev_req && floor_req != '0) begin
          if (exp_req.size() == 0) chk("unexpected_req", int'(floor_req), 0);
          else chk("floor_req", int'(floor_req), int'(exp_req.pop_front()));
        end
        if (door_open && !prev_door) begin
          if (exp_stop.size() == 0) begin
            chk("unexpected_door", int'(door_open), 0);
            cur_dwell = DW;
          end else begin
            stop_t s;
            s = exp_stop.pop_front();
            chk("stop_floor", int'(car_floor), s.floor);
            chk("stop_dir", int'(dir_up), int'(s.dir));
            chk("stop_cleared", int'((pending >> car_floor) & 5'b1), 0);
            chk("stop_req_zero", int'(floor_req), 0);
            cur_dwell = s.dwell;
          end
          door_cnt = 1;
        end else if (door_open) begin
          door_cnt++;
        end
        if (!door_open && prev_door) chk("dwell_len", door_cnt, cur_dwell);
        prev_req  = floor_req;
        prev_door = door_open;
      end
    end
  end

  task automatic expect_now(input string name, input int sel, input int exp);
    dq.push_back('{name, sel, 0, exp});
  endtask

  task automatic expect_val(input string name, input int val, input int exp);
    dq.push_back('{name, 99, val, exp});
  endtask

  task automatic push_stop(input int f, input bit d, input int dw);
    exp_stop.push_back('{f, d, dw});
  endtask

  // Simple car: three cycles per floor toward the requested floor.
  task automatic plant_update();
    int tf;
    if (floor_req == '0) begin
      car_stopped = 1'b1;
      move_cnt    = 0;
      return;
    end
    tf = 0;
    for (int i = 0; i < N; i++) if (floor_req[i]) tf = i;
    if (int'(car_floor) == tf) begin
      car_stopped = 1'b1;
      move_cnt    = 0;
    end else begin
      car_stopped = 1'b0;
      move_cnt++;
      if (move_cnt >= 3) begin
        move_cnt = 0;
        if (int'(car_floor) < tf) car_floor = car_floor + 3'd1;
        else car_floor = car_floor - 3'd1;
        car_stopped = (int'(car_floor) == tf);
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (car_auto) plant_update();
    end
  endtask

  task automatic wait_idle();
    int quiet;
    int cyc;
    quiet = 0;
    cyc   = 0;
    while (quiet < 3 && cyc < 3000) begin
      step(1);
      cyc++;
      if (!busy && exp_req.size() == 0 && exp_stop.size() == 0) quiet++;
      else quiet = 0;
    end
    expect_val("idle_wait", quiet, 3);
  endtask

  // Reference SCAN ordering for a set of calls pressed together at an idle
  // panel: own floor first, then all calls ahead nearest-first, then all
  // calls behind nearest-first.
  task automatic batch(input logic [N-1:0] mask, input int hold);
    int pos;
    bit d;
    int order[$];
    pos = int'(car_floor);
    d   = mdir;
    if (mask[pos]) push_stop(pos, d, DW);
    if (d) begin
      for (int f = pos + 1; f < N; f++) if (mask[f]) order.push_back(f);
      for (int f = pos - 1; f >= 0; f--) if (mask[f]) order.push_back(f);
    end else begin
      for (int f = pos - 1; f >= 0; f--) if (mask[f]) order.push_back(f);
      for (int f = pos + 1; f < N; f++) if (mask[f]) order.push_back(f);
    end
    foreach (order[j]) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[order[j]] = 1'b1;
      exp_req.push_back(oh);
      d = (order[j] > pos);
      push_stop(order[j], d, DW);
      pos = order[j];
    end
    mdir     = d;
    car_auto = 1'b1;
    btn      = mask;
    step(hold);
    btn      = '0;
    wait_idle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset values
    rst = 1'b1;
    step(2);
    expect_now("rst_floor_req", 0, 0);
    expect_now("rst_pending", 1, 0);
    expect_now("rst_door_open", 2, 0);
    expect_now("rst_dir_up", 3, 1);
    expect_now("rst_busy", 4, 0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single call from floor 0 to floor 2
    car_auto = 1'b0;
    car_floor = 3'd0;
    car_stopped = 1'b1;
    step(1);
    exp_req.push_back(5'b00100);
    push_stop(2, 1'b1, DW);
    btn = 5'b00100;
    step(1);
    btn = '0;
    expect_now("sc_pending", 1, 'b00100);
    expect_now("sc_req_early", 0, 0);
    step(1);
    expect_now("sc_req", 0, 'b00100);
    expect_now("sc_dir", 3, 1);
    expect_now("sc_busy", 4, 1);
    car_floor = 3'd2;
    step(1);
    expect_now("sc_pending_clr", 1, 0);
    expect_now("sc_door", 2, 1);
    mdir = 1'b1;
    wait_idle();

    // SCAN order: car at 2 heading up, calls at 0, 3, 4
    batch(5'b11001, 1);

    // Retarget: heading from 1 to 4, call at 2 appears
    car_auto = 1'b0;
    car_floor = 3'd1;
    car_stopped = 1'b1;
    step(1);
    exp_req.push_back(5'b10000);
    btn = 5'b10000;
    step(1);
    btn = '0;
    step(1);
    expect_now("rt_first", 0, 'b10000);
    car_stopped = 1'b0;
    exp_req.push_back(5'b00100);
    push_stop(2, 1'b1, DW);
    exp_req.push_back(5'b10000);
    push_stop(4, 1'b1, DW);
    btn = 5'b00100;
    step(1);
    btn = '0;
    expect_now("rt_hold", 0, 'b10000);
    step(1);
    expect_now("rt_new", 0, 'b00100);
    expect_now("rt_pending", 1, 'b10100);
    car_auto = 1'b1;
    mdir = 1'b1;
    wait_idle();

    // Door extend at floor 3: press again on dwell cycle 5
    car_auto = 1'b0;
    car_floor = 3'd3;
    car_stopped = 1'b1;
    step(1);
    push_stop(3, mdir, 5 + DW);
    btn = 5'b01000;
    step(1);
    btn = '0;
    step(1);
    expect_now("de_door", 2, 1);
    step(4);
    btn = 5'b01000;
    step(1);
    btn = '0;
    expect_now("de_pending", 1, 0);
    expect_now("de_door_still", 2, 1);
    wait_idle();

    // At-floor call with the button held for 20 cycles
    car_floor = 3'd1;
    car_stopped = 1'b1;
    step(1);
    push_stop(1, mdir, DW);
    btn = 5'b00010;
    step(20);
    btn = '0;
    expect_now("held_pending", 1, 0);
    expect_now("held_req", 0, 0);
    wait_idle();

    // Out-of-range car position: call waits until a real floor is reported
    car_floor = 3'd6;
    car_stopped = 1'b1;
    step(1);
    btn = 5'b00100;
    step(1);
    btn = '0;
    step(4);
    expect_now("inv_req", 0, 0);
    expect_now("inv_busy", 4, 0);
    expect_now("inv_pending", 1, 'b00100);
    step(1);
    exp_req.push_back(5'b00100);
    push_stop(2, 1'b1, DW);
    car_floor = 3'd0;
    mdir = 1'b1;
    car_auto = 1'b1;
    wait_idle();

    // Randomized call batches
    for (int t = 0; t < 12; t++) begin
      logic [N-1:0] m;
      int           h;
      m = N'($urandom_range(1, 31));
      h = int'($urandom_range(1, 3));
      batch(m, h);
    end

    // Asynchronous reset in the middle of SERVE
    car_auto = 1'b0;
    car_floor = 3'd3;
    car_stopped = 1'b1;
    step(1);
    exp_req.push_back(5'b00010);
    btn = 5'b00011;
    step(1);
    btn = '0;
    step(1);
    expect_now("rs_req", 0, 'b00010);
    expect_now("rs_dir", 3, 0);
    car_stopped = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_val("rs_floor_req_async", int'(floor_req), 0);
    expect_val("rs_pending_async", int'(pending), 0);
    expect_val("rs_door_async", int'(door_open), 0);
    expect_val("rs_dir_async", int'(dir_up), 1);
    expect_val("rs_busy_async", int'(busy), 0);
    car_stopped = 1'b1;
    step(2);
    rst = 1'b0;
    mdir = 1'b1;
    wait_idle();
    expect_now("rs_pending_after", 1, 0);

    expect_val("exp_req_drained", exp_req.size(), 0);
    expect_val("exp_stop_drained", exp_stop.size(), 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
